// File: rtl/sm3_pkg.sv
// rtl/sm3_pkg.sv - shared widths, FSM encoding and helpers for the SM3 arbiter
//   SM3_MSG_W / SM3_APP_W / SM3_DIG_W : message, append-word and digest widths
//   ST_*                               : one-hot arbiter state encoding
//   port_onehot()                      : port index to 2-bit one-hot vector
package sm3_pkg;

  localparam int SM3_MSG_W = 512;
  localparam int SM3_APP_W = 32;
  localparam int SM3_DIG_W = 256;

  localparam int ST_W = 5;
  localparam logic [ST_W-1:0] ST_IDLE  = 5'b00001;
  localparam logic [ST_W-1:0] ST_ISSUE = 5'b00010;
  localparam logic [ST_W-1:0] ST_WAIT  = 5'b00100;
  localparam logic [ST_W-1:0] ST_DONE  = 5'b01000;
  localparam logic [ST_W-1:0] ST_HALT  = 5'b10000;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sm3_arbiter_if.sv
// rtl/sm3_arbiter_if.sv - client-side and core-side signal bundle of the SM3 arbiter
//   client side : req, datain0/1, appendin0/1 in; gnt, done, err, hashout, fault out
//   core side   : core_datain, core_appendin, core_start out; core_hashout, core_valid in
//   slave modport is the arbiter view, master modport the view of clients plus core
interface sm3_arbiter_if;
  import sm3_pkg::*;

  logic [1:0]           req;
  logic [SM3_MSG_W-1:0] datain0;
  logic [SM3_MSG_W-1:0] datain1;
  logic [SM3_APP_W-1:0] appendin0;
  logic [SM3_APP_W-1:0] appendin1;
  logic [1:0]           gnt;
  logic [1:0]           done;
  logic [1:0]           err;
  logic [SM3_DIG_W-1:0] hashout;
  logic                 fault;

  logic [SM3_MSG_W-1:0] core_datain;
  logic [SM3_APP_W-1:0] core_appendin;
  logic                 core_start;
  logic [SM3_DIG_W-1:0] core_hashout;
  logic                 core_valid;

  modport slave (
    input  req, datain0, datain1, appendin0, appendin1, core_hashout, core_valid,
    output gnt, done, err, hashout, fault, core_datain, core_appendin, core_start
  );

  modport master (
    output req, datain0, datain1, appendin0, appendin1, core_hashout, core_valid,
    input  gnt, done, err, hashout, fault, core_datain, core_appendin, core_start
  );

endinterface

// File: rtl/sm3_arbiter.sv
// rtl/sm3_arbiter.sv - two-port round-robin arbiter and sequencer for one shared SM3 core
//   clk, rstn : clock and asynchronous active-low reset
//   bus       : sm3_arbiter_if.slave (client requests/results and core drive/response)
//   TIMEOUT   : WAIT cycles tolerated before the watchdog latches a fault (1..65535)
module sm3_arbiter
  import sm3_pkg::*;
#(
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic         clk,
  input  logic         rstn,
  sm3_arbiter_if.slave bus
);

  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);

  logic [ST_W-1:0]      state;
  logic                 owner;
  logic                 rr;
  logic                 pick;
  logic                 owns;
  logic [15:0]          wd_cnt;
  logic [15:0]          wd_inc;
  logic [1:0]           err_q;
  logic                 fault_q;
  logic [SM3_DIG_W-1:0] hash_q;
  logic [SM3_MSG_W-1:0] cdata_q;
  logic [SM3_APP_W-1:0] capp_q;

  always_comb begin
    // Lone requester wins; under contention the round-robin pointer decides.
    pick   = bus.req[1] & (~bus.req[0] | rr);
    // Watchdog counter saturates rather than wrapping.
    wd_inc = (wd_cnt == 16'hFFFF) ? wd_cnt : wd_cnt + 16'd1;
    owns   = (state == ST_ISSUE) || (state == ST_WAIT) || (state == ST_DONE);
  end

  assign bus.gnt           = owns ? port_onehot(owner) : 2'b00;
  assign bus.done          = (state == ST_DONE) ? port_onehot(owner) : 2'b00;
  assign bus.core_start    = (state == ST_ISSUE);
  assign bus.err           = err_q;
  assign bus.fault         = fault_q;
  assign bus.hashout       = hash_q;
  assign bus.core_datain   = cdata_q;
  assign bus.core_appendin = capp_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      owner   <= 1'b0;
      rr      <= 1'b0;
      wd_cnt  <= 16'd0;
      err_q   <= 2'b00;
      fault_q <= 1'b0;
      hash_q  <= '0;
      cdata_q <= '0;
      capp_q  <= '0;
    end else begin
      err_q <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (|bus.req) begin
            owner   <= pick;
            cdata_q <= pick ? bus.datain1 : bus.datain0;
            capp_q  <= pick ? bus.appendin1 : bus.appendin0;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wd_cnt <= 16'd0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          // A valid on the final counted cycle still completes the job.
          if (bus.core_valid) begin
            hash_q <= bus.core_hashout;
            state  <= ST_DONE;
          end else begin
            wd_cnt <= wd_inc;
            if (wd_inc >= WD_LIMIT) begin
              err_q   <= port_onehot(owner);
              fault_q <= 1'b1;
              state   <= ST_HALT;
            end
          end
        end
        ST_DONE: begin
          rr    <= ~owner;
          state <= ST_IDLE;
        end
        ST_HALT: begin
          state <= ST_HALT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sm3_arbiter.sv
// tb/tb_sm3_arbiter.sv - scoreboard testbench for sm3_arbiter with a behavioural core model
module tb_sm3_arbiter;
  import sm3_pkg::*;

  localparam int TB_TIMEOUT = 100;

  typedef struct {
    bit           is_err;
    bit           port;
    logic [255:0] dig;
    int           cyc;
  } resp_t;

  typedef struct {
    bit           port;
    logic [511:0] data;
    logic [31:0]  app;
    int           cyc;
  } iss_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sm3_arbiter_if bus();

  sm3_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  resp_t resp_q[$];
  iss_t  iss_q[$];
  int    checks = 0;
  int    passed = 0;
  int    cyc = 0;
  int    done_seen = 0;
  bit    gnt1_seen = 0;
  logic  [1:0] prev_gnt = 2'b00;

  int           model_lat = 4;
  int           model_hold = 1;
  bit           model_hang = 0;
  logic         model_valid = 1'b0;
  logic         inject_valid = 1'b0;
  logic [255:0] model_hash = '0;

  bit           rr_m = 0;
  logic [255:0] last_dig = '0;

  assign bus.core_valid   = model_valid | inject_valid;
  assign bus.core_hashout = model_hash;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] toy_digest(input logic [511:0] d, input logic [31:0] a);
    return d[511:256] ^ {d[254:0], d[255]} ^ {8{a}};
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural core: answers model_lat cycles after start, holds valid model_hold cycles.
  always begin : core_model
    logic [511:0] d;
    logic [31:0]  a;
    bit           aborted;
    @(negedge clk);
    if (rstn && bus.core_start && !model_hang) begin
      d = bus.core_datain;
      a = bus.core_appendin;
      aborted = 0;
      for (int i = 0; i < model_lat && !aborted; i++) begin
        @(posedge clk);
        if (!rstn) aborted = 1;
      end
      if (!aborted) begin
        #1;
        model_hash  = toy_digest(d, a);
        model_valid = 1'b1;
        for (int i = 0; i < model_hold; i++) begin
          @(posedge clk);
          if (!rstn) break;
        end
        #1;
        model_valid = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT issues a start or reports a result.
  always @(negedge clk) begin : monitor
    iss_t  ie;
    resp_t re;
    if (rstn) begin
      if (bus.gnt[1]) gnt1_seen = 1;
      if (bus.core_start) begin
        check("start_after_idle_gnt", prev_gnt, 2'b00);
        check("issue_expected", iss_q.size() > 0, 1'b1);
        if (iss_q.size() > 0) begin
          ie = iss_q.pop_front();
          check("issue_gnt", bus.gnt, port_onehot(ie.port));
          check("issue_appendin", bus.core_appendin, ie.app);
          check("issue_datain", bus.core_datain, ie.data);
          if (ie.cyc >= 0) check("issue_cycle", cyc, ie.cyc);
        end
      end
      if (bus.done != 2'b00 || bus.err != 2'b00) begin
        if (bus.done != 2'b00) done_seen++;
        check("resp_expected", resp_q.size() > 0, 1'b1);
        if (resp_q.size() > 0) begin
          re = resp_q.pop_front();
          check("resp_kind", bus.err != 2'b00, re.is_err);
          if (re.is_err) begin
            check("err_port", bus.err, port_onehot(re.port));
            check("fault_with_err", bus.fault, 1'b1);
          end else begin
            check("done_port", bus.done, port_onehot(re.port));
            check("hashout", bus.hashout, re.dig);
          end
          if (re.cyc >= 0) check("resp_cycle", cyc, re.cyc);
        end
      end
    end
    prev_gnt = bus.gnt;
  end

  task automatic push_job(input bit p, input logic [511:0] d, input logic [31:0] a,
                          input int icyc, input int dcyc);
    iss_q.push_back('{p, d, a, icyc});
    resp_q.push_back('{1'b0, p, toy_digest(d, a), dcyc});
    last_dig = toy_digest(d, a);
    rr_m = ~p;
  endtask

  task automatic wait_gnt(input bit p);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.gnt[p]) break;
    end
    check("gnt_rise", bus.gnt[p], 1'b1);
  endtask

  task automatic wait_drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (resp_q.size() == 0 && iss_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("queues_drained", resp_q.size() + iss_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, bus.gnt, 2'b00);
    check({tag, "_done"}, bus.done, 2'b00);
    check({tag, "_err"}, bus.err, 2'b00);
    check({tag, "_fault"}, bus.fault, 1'b0);
    check({tag, "_core_start"}, bus.core_start, 1'b0);
    check({tag, "_hashout"}, bus.hashout, 256'd0);
    check({tag, "_core_datain"}, bus.core_datain, 512'd0);
    check({tag, "_core_appendin"}, bus.core_appendin, 32'd0);
  endtask

  // Holds pat until njobs completions are seen; expected owners follow the alternation rule.
  task automatic run_round(input logic [1:0] pat, input int njobs);
    logic [511:0] d0, d1;
    logic [31:0]  a0, a1;
    bit           p;
    int           seen;
    d0 = rand512();
    d1 = rand512();
    a0 = $urandom;
    a1 = $urandom;
    bus.datain0 = d0;
    bus.datain1 = d1;
    bus.appendin0 = a0;
    bus.appendin1 = a1;
    p = (pat == 2'b11) ? rr_m : pat[1];
    for (int j = 0; j < njobs; j++) begin
      push_job(p, p ? d1 : d0, p ? a1 : a0, -1, -1);
      if (pat == 2'b11) p = ~p;
    end
    model_lat = $urandom_range(1, 30);
    bus.req = pat;
    seen = 0;
    for (int i = 0; i < njobs * 150 && seen < njobs; i++) begin
      @(negedge clk);
      if (bus.done != 2'b00) seen++;
    end
    bus.req = 2'b00;
    check("round_jobs", seen, njobs);
    wait_drain(60);
  endtask

  initial begin : stimulus
    logic [511:0] abc_blk;
    logic [511:0] d;
    logic [31:0]  a;
    int           c0;
    int           base;
    int           bad;
    bit           p;

    abc_blk = {24'h616263, 8'h80, 416'd0, 64'd24};
    bus.req = 2'b00;
    bus.datain0 = '0;
    bus.datain1 = '0;
    bus.appendin0 = '0;
    bus.appendin1 = '0;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Contention from reset: strict alternation starting with port 0.
    run_round(2'b11, 4);

    // Single port-0 job with fixed latency and exact cycle checks.
    gnt1_seen = 0;
    model_lat = 64;
    bus.datain0 = abc_blk;
    bus.appendin0 = 32'd1;
    c0 = cyc;
    push_job(1'b0, abc_blk, 32'd1, c0 + 1, c0 + 66);
    bus.req = 2'b01;
    wait_gnt(1'b0);
    bus.req = 2'b00;
    wait_drain(120);
    check("gnt1_never_set", gnt1_seen, 1'b0);

    // Port 1 drops req and changes its data one cycle after grant.
    d = rand512();
    a = $urandom;
    bus.datain1 = d;
    bus.appendin1 = a;
    model_lat = 10;
    base = done_seen;
    push_job(1'b1, d, a, -1, -1);
    bus.req = 2'b10;
    wait_gnt(1'b1);
    @(posedge clk);
    #1;
    bus.req = 2'b00;
    bus.datain1 = rand512();
    bus.appendin1 = $urandom;
    wait_drain(60);
    repeat (4) @(posedge clk);
    #1;
    check("drop_req_single_done", done_seen - base, 1);

    // Valid pulse in IDLE is ignored; a 3-cycle valid level yields one done.
    base = done_seen;
    inject_valid = 1'b1;
    @(posedge clk);
    #1;
    inject_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_valid_no_done", done_seen - base, 0);
    check("idle_valid_hash_held", bus.hashout, last_dig);
    model_hold = 3;
    d = rand512();
    a = $urandom;
    bus.datain0 = d;
    bus.appendin0 = a;
    push_job(1'b0, d, a, -1, -1);
    bus.req = 2'b01;
    wait_gnt(1'b0);
    bus.req = 2'b00;
    wait_drain(60);
    repeat (5) @(posedge clk);
    #1;
    check("level_valid_one_done", done_seen - base, 1);
    model_hold = 1;

    // Randomised rounds of single and contended requests.
    for (int r = 0; r < 6; r++) begin
      case ($urandom_range(0, 2))
        0: run_round(2'b01, $urandom_range(1, 3));
        1: run_round(2'b10, $urandom_range(1, 3));
        default: run_round(2'b11, $urandom_range(2, 4));
      endcase
    end

    // Valid on the last WAIT cycle the watchdog allows still completes.
    model_lat = TB_TIMEOUT;
    d = rand512();
    a = $urandom;
    bus.datain0 = d;
    bus.appendin0 = a;
    c0 = cyc;
    push_job(1'b0, d, a, c0 + 1, c0 + TB_TIMEOUT + 2);
    bus.req = 2'b01;
    wait_gnt(1'b0);
    bus.req = 2'b00;
    wait_drain(TB_TIMEOUT + 20);
    check("boundary_no_fault", bus.fault, 1'b0);

    // Reset during WAIT: outputs clear at once, rr returns to port 0.
    model_lat = 50;
    d = rand512();
    bus.datain0 = d;
    bus.appendin0 = 32'hA5A5_0001;
    iss_q.push_back('{1'b0, d, 32'hA5A5_0001, -1});
    bus.req = 2'b01;
    wait_gnt(1'b0);
    bus.req = 2'b00;
    repeat (10) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("async_reset");
    resp_q.delete();
    iss_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    rr_m = 0;
    @(posedge clk);
    #1;
    run_round(2'b11, 2);

    // Watchdog: the core never answers.
    model_hang = 1;
    p = $urandom_range(0, 1);
    d = rand512();
    a = $urandom;
    if (p) begin
      bus.datain1 = d;
      bus.appendin1 = a;
    end else begin
      bus.datain0 = d;
      bus.appendin0 = a;
    end
    c0 = cyc;
    iss_q.push_back('{p, d, a, c0 + 1});
    resp_q.push_back('{1'b1, p, 256'd0, c0 + TB_TIMEOUT + 2});
    bus.req = port_onehot(p);
    wait_gnt(p);
    bus.req = 2'b11;
    wait_drain(TB_TIMEOUT + 20);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.gnt != 2'b00 || bus.core_start || bus.done != 2'b00) bad++;
    end
    check("halt_ignores_req", bad, 0);
    check("fault_sticky", bus.fault, 1'b1);
    bus.req = 2'b00;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check("fault_cleared_by_reset", bus.fault, 1'b0);
    model_hang = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    rr_m = 0;
    @(posedge clk);
    #1;
    run_round(2'b01, 1);
    run_round(2'b11, 3);

    check("final_queues_empty", resp_q.size() + iss_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sm3_arbiter.md
# sm3_arbiter

Two-port arbiter and sequencer for the single shared `sm3_1024_top` hash core. Lets two SM2 clients, the KDF engine (port 0) and the ZA/e-digest engine (port 1), issue 512-bit message plus 32-bit append hash jobs without instantiating a second core. Captures each request, drives one core start, waits for the core's valid, returns the 256-bit digest to the owner, then rotates priority. Includes a watchdog that latches a fault if the core never answers.

## Interface
- `TIMEOUT`, default 4095: maximum cycles spent in WAIT before the fault trips; range 1..65535.
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req`  in  2  per-port job request, level-sensitive; bit i belongs to port i.
- `datain0`, `datain1`  in  512 each  message block for each port.
- `appendin0`, `appendin1`  in  32 each  append word (counter) for each port.
- `gnt`  out  2  one-hot; set while the port owns the core (ISSUE, WAIT, DONE).
- `done`  out  2  one-cycle pulse to the owner when `hashout` is valid.
- `err`  out  2  one-cycle pulse to the owner on watchdog expiry.
- `hashout`  out  256  registered digest of the last completed job; held until the next completion.
- `fault`  out  1  sticky watchdog flag; cleared only by `rstn`.
- `core_datain`  out  512  to core `datain`.
- `core_appendin`  out  32  to core `appendin`.
- `core_start`  out  1  to core `start`.
- `core_hashout`  in  256  from core `hashout`.
- `core_valid`  in  1  from core `valid`.

## Operation
- States: IDLE, ISSUE, WAIT, DONE, HALT.
- IDLE
  - If any `req` bit is set, pick the owner. When only one bit is set, that port wins. When both are set, the port selected by the round-robin pointer `rr` wins.
  - Latch the owner's `datain` and `appendin` into `core_datain` and `core_appendin`, then go to ISSUE.
- ISSUE: `core_start`=1 for exactly this cycle. Clear the watchdog counter. Go to WAIT.
- WAIT
  - On the first cycle `core_valid`=1, capture `core_hashout` into `hashout` and go to DONE.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`, pulse `err[owner]`, set `fault`, and go to HALT.
- DONE: `done[owner]`=1 for this cycle. Set `rr` to the other port. Return to IDLE.
- HALT: terminal state. `gnt` and `core_start` stay 0, all `req` is ignored, and exit is only through `rstn`.
- `core_valid` is ignored outside WAIT. It may be a pulse or a level; only its first high cycle in WAIT counts.
- Requester data is captured at the IDLE to ISSUE edge. The requester may change its data or drop `req` once `gnt` rises. Dropping `req` mid-job does not abort the job.
- A `req` still high after `done` counts as a new request. Because `rr` has rotated, the other port wins if both are requesting. This gives strict alternation under contention.
- The watchdog counter is 16 bits wide and saturates. It is compared with `>=` against `TIMEOUT`.
- Reset mid-job: every state and output goes to its reset value immediately and the job is lost. The core is reset by the same `rstn`.

## Timing
- Reset values: state=IDLE, `rr`=0 (port 0 favoured first). `gnt`, `done`, `err`, `fault`, `core_start`, `hashout`, `core_datain`, `core_appendin` are all 0.
- Cycle 0: `req` sampled high in IDLE.
- Cycle 1: ISSUE. `gnt[owner]`=1, `core_start`=1, core inputs stable.
- `core_datain` and `core_appendin` are held from cycle 1 until the next ISSUE.
- `core_valid` first seen high at cycle N (N ≥ 2): at N+1 the state is DONE, `done`=1 and `hashout` is valid.
- At N+2 the state is IDLE and `gnt`=0. The earliest next ISSUE is N+3.
- Arbitration overhead: 3 cycles per job on top of core latency.
- Watchdog: `err` pulses at cycle 2+`TIMEOUT` if no valid arrives. `fault` rises in the same cycle.

## Structure
- Shared package `sm3_pkg`:
  - Widths: `SM3_MSG_W`=512, `SM3_APP_W`=32, `SM3_DIG_W`=256.
  - The state encoding as one-hot localparams, matching the SM2 block convention.
- Single module with no sub-modules. The core is instantiated by the parent alongside the arbiter, so the bench can drive the core-side ports with a behavioural model that has configurable latency.

## Test plan
- Single port-0 request, datain0={"abc" padded}, appendin0=1, model latency 64 → `core_start` pulse at cycle 1, `done[0]` at cycle 66, `hashout`=model digest, `gnt[1]` never set.
- Both `req` high from reset and held → grant order 0,1,0,1. `core_appendin` matches the owner's value on every ISSUE. No start is issued while `gnt` is nonzero from a previous job.
- Port 1 drops `req` and changes datain1 one cycle after `gnt[1]` → job completes with the originally latched data, `done[1]` pulses once.
- Model never asserts valid, `TIMEOUT`=16 → `err[owner]` and `fault` rise at cycle 18. Further `req` is ignored. `rstn` low clears `fault` and returns to IDLE.
- `core_valid` pulsed while in IDLE, then held high as a level for 3 cycles in WAIT → the idle pulse is ignored and exactly one `done` is produced.
- `rstn` asserted during WAIT → all outputs zero asynchronously. After release, a new port-0 request completes normally with `rr`=0.
